// File: rtl/sobel_edge.sv
// Sobel gradient magnitude and thresholded edge bit for a 3x3 pixel window, with column/row border suppression.
// Fixed 3-clock latency; valid bubbles pass through unchanged; no backpressure (one window per clock).
module sobel_edge #(
  parameter int COLS    = 640,
  parameter int ROWS    = 480,
  parameter int LATENCY = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        sof,
  input  logic [71:0] matrix,
  input  logic [7:0]  threshold,
  output logic        out_valid,
  output logic [7:0]  edge_mag,
  output logic        edge_bit
);

  localparam int CW = (COLS > 4) ? $clog2(COLS) : 2;
  localparam int RW = (ROWS > 4) ? $clog2(ROWS) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [9:0] c;
    logic [9:0] d;
  } sums_t;

  typedef struct packed {
    logic [9:0] gx;
    logic [9:0] gy;
  } grad_t;

  // Weighted column/row sum p + 2*q + r; never exceeds 1020.
  function automatic logic [9:0] tap3(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r);
    return {2'b00, p} + {1'b0, q, 1'b0} + {2'b00, r};
  endfunction

  function automatic logic [9:0] absdiff(input logic [9:0] p, input logic [9:0] m);
    logic [10:0] d;
    d = {1'b0, p} - {1'b0, m};
    return d[10] ? (m - p) : d[9:0];
  endfunction

  logic [8:0][7:0] z;
  assign z = matrix;

  // The centre tap never contributes to either gradient.
  logic unused_centre;
  assign unused_centre = ^z[4];

  logic [CW-1:0] col_cnt, cur_col, col_nxt;
  logic [RW-1:0] row_cnt, cur_row, row_nxt;
  logic          interior;

  always_comb begin
    cur_col = sof ? '0 : col_cnt;
    cur_row = sof ? '0 : row_cnt;
    col_nxt = cur_col + CW'(1);
    row_nxt = cur_row;
    if (cur_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
    interior = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (in_valid) begin
      col_cnt <= col_nxt;
      row_cnt <= row_nxt;
    end
  end

  logic [LATENCY-1:0] vld_pipe;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[LATENCY-2:0], in_valid};
    end
  end

  assign out_valid = vld_pipe[LATENCY-1];

  sums_t s1_sums;
  logic  s1_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_sums <= '0;
      s1_int  <= 1'b0;
    end else if (in_valid) begin
      s1_sums.a <= tap3(z[6], z[3], z[0]);
      s1_sums.b <= tap3(z[8], z[5], z[2]);
      s1_sums.c <= tap3(z[8], z[7], z[6]);
      s1_sums.d <= tap3(z[2], z[1], z[0]);
      s1_int    <= interior;
    end
  end

  // Gx = A - B and Gy = C - D, kept only as magnitudes.
  grad_t s2_grad;
  logic  s2_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_grad <= '0;
      s2_int  <= 1'b0;
    end else if (vld_pipe[0]) begin
      s2_grad.gx <= absdiff(s1_sums.a, s1_sums.b);
      s2_grad.gy <= absdiff(s1_sums.c, s1_sums.d);
      s2_int     <= s1_int;
    end
  end

  logic [10:0] mag_sum;
  logic [7:0]  mag_sat;

  always_comb begin
    mag_sum = {1'b0, s2_grad.gx} + {1'b0, s2_grad.gy};
    mag_sat = (mag_sum > 11'd255) ? 8'hFF : mag_sum[7:0];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      edge_mag <= '0;
      edge_bit <= 1'b0;
    end else if (vld_pipe[1]) begin
      edge_mag <= s2_int ? mag_sat : 8'd0;
      edge_bit <= s2_int && (mag_sat >= threshold);
    end
  end

endmodule
